lse_simd_nch: RTL and testbench
===============================

Name: lse_simd_nch

Overview:
- Parametrised N-lane SIMD log-sum-exp engine; next generation of the fixed 2-lane LSE adder.
- Generalised in lane count and lane width.
- Adds a 3-stage pipeline with valid/ready backpressure, a per-lane enable mask, four PE modes, and saturation detection.
- Sits between the operand fetch and the accumulator of a log-domain PE.

Parameters:
NUM_CH, 4, number of lanes (1..8)
CH_WIDTH, 12, unsigned fixed-point lane width
LUT_SIZE, 16, correction LUT entries (power of two)
LUT_PRECISION, 10, LUT entry width; must be <= CH_WIDTH
LUT_SHIFT, 2, right shift applied to |a-b| to form the LUT index
DATA_WIDTH, NUM_CH*CH_WIDTH, packed width; derived localparam, not overridable

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat
x_in  in  DATA_WIDTH  operand A; lane k at [k*CH_WIDTH +: CH_WIDTH]
y_in  in  DATA_WIDTH  operand B; same packing as x_in
lane_en  in  NUM_CH  per-lane enable; captured with the beat
pe_mode  in  2  00 LSE, 01 MAX, 10 ADD, 11 PASS-A; captured with the beat
lut_table  in  LUT_SIZE x LUT_PRECISION  correction table; quasi-static
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts the beat
result  out  DATA_WIDTH  packed lane results
sat  out  NUM_CH  per-lane saturation flag for the current output beat

Behaviour:
- Reset: clk and one clock domain only. rst_n is asynchronous, active-low.
  - All stage valid bits, out_valid, result and sat reset to 0.
  - in_ready reads 1 one cycle after deassertion, when out_ready=1 or the pipeline is empty.
  - Reset mid-operation discards all in-flight beats; nothing is replayed.
- Handshake:
  - Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
  - Stage i advances when stage i+1 is empty or advancing (bubble collapsing).
  - in_ready = !s1_valid || s1_advance.
  - Data registers hold while stalled. out_valid/result are stable until accepted.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput: 1 beat/cycle.
- Pipeline stages, per lane:
  - S1: register a, b, mode, lane_en. Compute m = max(a,b) and d = |a-b| (CH_WIDTH bits). In ADD mode also compute s = a+b with CH_WIDTH+1 bits.
  - S2: idx = d >> LUT_SHIFT. corr = lut_table[idx] zero-extended to CH_WIDTH when idx < LUT_SIZE, else corr = 0.
  - S3, by mode, with sum width CH_WIDTH+1 before saturation:
    - LSE: r = m + corr
    - MAX: r = m
    - ADD: r = s
    - PASS-A: r = a
    - If r exceeds all-ones: output all-ones and sat=1; otherwise sat=0.
- Masked lane (lane_en bit 0): result lane = 0, sat = 0, independent of mode.
- lut_table is sampled in S2 at the cycle the beat occupies S2. Changing it while beats are in flight is legal; each beat uses the value current at its S2 cycle.
- Lanes are fully independent; there is no carry across lane boundaries.

Optional Feature:
- Macro: LSE_SIMD_SAT_CNT_EN.
- Defined: adds output port sat_count (16 bits) and input port sat_clr (1 bit).
  - sat_count increments by popcount(sat) on each output transfer and saturates at 0xFFFF.
  - sat_clr clears it synchronously; clear takes priority over increment in the same cycle.
  - Reset value is 0.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package lse_simd_pkg holds:
  - typedef enum pe_mode_e {PE_LSE, PE_MAX, PE_ADD, PE_PASS}
  - stage struct typedef {valid, mode, lane_en}
  - function sat_add(width-generic via parameterised class or macro)
- One sub-module, lse_lane_pipe: single-lane 3-stage datapath, no handshake logic.
  - Instantiated NUM_CH times by generate.
  - Top owns the shared valid/advance control.

Test Plan (NUM_CH=4, CH_WIDTH=12, LUT_SHIFT=2, lut_table[i]=44-2*i):
- LSE, all lanes x=100, y=100, lane_en=1111, out_ready=1 -> after 3 cycles every lane = 144 (d=0, corr 44), sat=0000.
- LSE, lane0 x=500 y=420 (idx 20, out of range) and lane1 x=4090 y=4090 -> lane0 = 500 with sat0=0; lane1 = 4095 with sat1=1.
- Modes on x=0x800, y=0x900:
  - MAX -> 0x900
  - ADD -> 0xFFF with sat=1
  - PASS -> 0x800
- lane_en=0101 on the LSE beat from scenario 1 -> lanes 1 and 3 = 0, lanes 0 and 2 = 144.
- Backpressure: stream 6 beats, hold out_ready=0 for 5 cycles.
  - in_ready drops after 3 beats are accepted.
  - result is held stable while stalled.
  - All 6 beats emerge in order with no loss or duplication.
- Assert rst_n low while 3 beats are in flight -> out_valid=0 and result=0 immediately (asynchronously). After release, the next single beat emerges with 3-cycle latency and no stale data.

Source files
------------

// File: rtl/lse_simd_pkg.sv
// ============================================================================
// lse_simd_pkg : shared types and saturating-add helper for lse_simd_nch
// Revision     : 1.0
// ============================================================================
`default_nettype none

package lse_simd_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    PE_LSE  = 2'b00,
    PE_MAX  = 2'b01,
    PE_ADD  = 2'b10,
    PE_PASS = 2'b11
  } pe_mode_e;

  typedef struct packed {
    logic              valid;
    pe_mode_e          mode;
    logic [MAX_CH-1:0] lane_en;
  } stage_t;

  // Width-generic saturating add: bit 32 is the saturation flag, the low w bits the clamped value.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (sum > lim) return {1'b1, lim[31:0]};
    return {1'b0, sum[31:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lse_lane_pipe.sv
// ============================================================================
// lse_lane_pipe : single-lane 3-stage LSE/MAX/ADD/PASS datapath (no handshake)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module lse_lane_pipe
  import lse_simd_pkg::*;
#(
  parameter int CH_WIDTH      = 12,
  parameter int LUT_SIZE      = 16,
  parameter int LUT_PRECISION = 10,
  parameter int LUT_SHIFT     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld1,
  input  logic                     ld2,
  input  logic                     ld3,
  input  logic [CH_WIDTH-1:0]      a_in,
  input  logic [CH_WIDTH-1:0]      b_in,
  input  pe_mode_e                 mode,
  input  logic                     lane_en,
  input  logic [LUT_PRECISION-1:0] lut_table [LUT_SIZE],
  output logic [CH_WIDTH-1:0]      result,
  output logic                     sat
);

  localparam int IDX_W = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1;

  logic [CH_WIDTH-1:0] a1, b1, m1, d1;
  logic [CH_WIDTH:0]   s1;
  logic [CH_WIDTH-1:0] a2, m2, d2;
  logic [CH_WIDTH:0]   s2;
  logic [CH_WIDTH-1:0] idx, corr;
  logic [32:0]         sum;
  logic                unused_sum_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1 <= '0;
      b1 <= '0;
    end else if (ld1) begin
      a1 <= a_in;
      b1 <= b_in;
    end
  end

  always_comb begin
    m1 = a1;
    d1 = a1 - b1;
    if (b1 > a1) begin
      m1 = b1;
      d1 = b1 - a1;
    end
    s1 = {1'b0, a1} + {1'b0, b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a2 <= '0;
      m2 <= '0;
      d2 <= '0;
      s2 <= '0;
    end else if (ld2) begin
      a2 <= a1;
      m2 <= m1;
      d2 <= d1;
      s2 <= s1;
    end
  end

  // The table is read while the beat sits in S2, so a table update reaches the next beat to pass.
  always_comb begin
    idx  = d2 >> LUT_SHIFT;
    corr = '0;
    if (32'(idx) < LUT_SIZE) corr = CH_WIDTH'(lut_table[idx[IDX_W-1:0]]);
    sum = '0;
    case (mode)
      PE_LSE:  sum = sat_add(32'(m2), 32'(corr), CH_WIDTH);
      PE_MAX:  sum = sat_add(32'(m2), 32'd0, CH_WIDTH);
      PE_ADD:  sum = sat_add(32'(s2), 32'd0, CH_WIDTH);
      PE_PASS: sum = sat_add(32'(a2), 32'd0, CH_WIDTH);
      default: sum = '0;
    endcase
  end

  assign unused_sum_bits = ^sum[31:CH_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      sat    <= 1'b0;
    end else if (ld3) begin
      result <= lane_en ? sum[CH_WIDTH-1:0] : '0;
      sat    <= lane_en & sum[32];
    end
  end

endmodule

`default_nettype wire

// File: rtl/lse_simd_nch.sv
// ============================================================================
// lse_simd_nch : N-lane pipelined log-sum-exp engine with valid/ready flow
// Optional     : LSE_SIMD_SAT_CNT_EN adds sat_count / sat_clr
// Revision     : 1.0
// ============================================================================
`default_nettype none

module lse_simd_nch
  import lse_simd_pkg::*;
#(
  parameter  int NUM_CH        = 4,
  parameter  int CH_WIDTH      = 12,
  parameter  int LUT_SIZE      = 16,
  parameter  int LUT_PRECISION = 10,
  parameter  int LUT_SHIFT     = 2,
  localparam int DATA_WIDTH    = NUM_CH * CH_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    x_in,
  input  logic [DATA_WIDTH-1:0]    y_in,
  input  logic [NUM_CH-1:0]        lane_en,
  input  logic [1:0]               pe_mode,
  input  logic [LUT_PRECISION-1:0] lut_table [LUT_SIZE],
`ifdef LSE_SIMD_SAT_CNT_EN
  input  logic                     sat_clr,
  output logic [15:0]              sat_count,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [NUM_CH-1:0]        sat
);

  stage_t st1, st2;
  logic   v3, init_done;
  logic   adv1, adv2, adv3, in_fire;

  assign out_valid = v3;
  assign adv3      = v3 && out_ready;
  assign adv2      = st2.valid && (!v3 || adv3);
  assign adv1      = st1.valid && (!st2.valid || adv2);
  assign in_ready  = init_done && (!st1.valid || adv1);
  assign in_fire   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      st1       <= '0;
      st2       <= '0;
      v3        <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (in_ready) st1.valid <= in_valid;
      if (in_fire) begin
        st1.mode    <= pe_mode_e'(pe_mode);
        st1.lane_en <= MAX_CH'(lane_en);
      end
      if (!st2.valid || adv2) st2.valid <= st1.valid;
      if (adv1) begin
        st2.mode    <= st1.mode;
        st2.lane_en <= st1.lane_en;
      end
      if (!v3 || out_ready) v3 <= st2.valid;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    lse_lane_pipe #(
      .CH_WIDTH      (CH_WIDTH),
      .LUT_SIZE      (LUT_SIZE),
      .LUT_PRECISION (LUT_PRECISION),
      .LUT_SHIFT     (LUT_SHIFT)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld1       (in_fire),
      .ld2       (adv1),
      .ld3       (adv2),
      .a_in      (x_in[k*CH_WIDTH +: CH_WIDTH]),
      .b_in      (y_in[k*CH_WIDTH +: CH_WIDTH]),
      .mode      (st2.mode),
      .lane_en   (st2.lane_en[k]),
      .lut_table (lut_table),
      .result    (result[k*CH_WIDTH +: CH_WIDTH]),
      .sat       (sat[k])
    );
  end

  if (NUM_CH < MAX_CH) begin : g_unused_en
    logic unused_en_bits;
    assign unused_en_bits = ^st2.lane_en[MAX_CH-1:NUM_CH];
  end

`ifdef LSE_SIMD_SAT_CNT_EN
  logic [3:0]  sat_pop;
  logic [16:0] cnt_sum;

  always_comb begin
    sat_pop = '0;
    for (int k = 0; k < NUM_CH; k++) sat_pop = sat_pop + 4'(sat[k]);
  end

  assign cnt_sum = {1'b0, sat_count} + 17'(sat_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sat_count <= '0;
    else if (sat_clr) sat_count <= '0;
    else if (adv3)    sat_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lse_simd_nch.sv
// ============================================================================
// tb_lse_simd_nch : directed + randomized bench against a lane-level reference model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_lse_simd_nch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] x_in, y_in;
  logic [3:0]  lane_en;
  logic [1:0]  pe_mode;
  logic [9:0]  lut [16];
  logic        out_valid;
  logic        out_ready;
  logic [47:0] result;
  logic [3:0]  sat;
  logic        sat_clr;
  logic [15:0] sat_count;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [51:0] exp_q[$];

  always #5 clk = ~clk;

  lse_simd_nch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .lane_en   (lane_en),
    .pe_mode   (pe_mode),
    .lut_table (lut),
`ifdef LSE_SIMD_SAT_CNT_EN
    .sat_clr   (sat_clr),
    .sat_count (sat_count),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sat       (sat)
  );

`ifndef LSE_SIMD_SAT_CNT_EN
  assign sat_count = '0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] rep(input logic [11:0] v);
    return {v, v, v, v};
  endfunction

  // Lane arithmetic from first principles: exact integer result, then clamp to 12 bits.
  function automatic logic [51:0] model(input logic [47:0] x, input logic [47:0] y,
                                        input logic [1:0] md, input logic [3:0] en);
    logic [47:0] r;
    logic [3:0]  s;
    int a, b, v, mx, d, idx;
    r = '0;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      a   = int'(x[k*12 +: 12]);
      b   = int'(y[k*12 +: 12]);
      mx  = (a > b) ? a : b;
      d   = (a > b) ? a - b : b - a;
      idx = d / 4;
      case (md)
        2'd0:    v = mx + ((idx < 16) ? int'(lut[idx]) : 0);
        2'd1:    v = mx;
        2'd2:    v = a + b;
        default: v = a;
      endcase
      if (en[k]) begin
        if (v > 4095) begin
          r[k*12 +: 12] = 12'hFFF;
          s[k] = 1'b1;
        end else begin
          r[k*12 +: 12] = 12'(v);
        end
      end
    end
    return {s, r};
  endfunction

  // Scoreboard: capture accepted beats, compare every visible output beat to the oldest pending one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(x_in, y_in, pe_mode, lane_en));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 64'd1, 64'd0);
        end else begin
          check("out_result", result, exp_q[0][47:0]);
          check("out_sat", sat, exp_q[0][51:48]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
    end
  end

  task automatic send_and_check(input string tag, input logic [47:0] x, input logic [47:0] y,
                                input logic [1:0] md, input logic [3:0] en,
                                input logic [47:0] er, input logic [3:0] es);
    int n;
    out_ready = 1'b1;
    x_in = x; y_in = y; pe_mode = md; lane_en = en; in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 3);
    check({tag, "_result"}, result, er);
    check({tag, "_sat"}, sat, es);
    @(posedge clk); #1;
  endtask

  // Offers a beat for one cycle; returns whether it was accepted.
  task automatic offer(input logic [47:0] x, input logic [47:0] y, input logic [1:0] md,
                       input logic [3:0] en, output logic acc);
    x_in = x; y_in = y; pe_mode = md; lane_en = en; in_valid = 1'b1;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   sent, base;
    logic [47:0] xv, yv;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    x_in = '0; y_in = '0; lane_en = 4'hF; pe_mode = 2'd0;
    for (int i = 0; i < 16; i++) lut[i] = 10'(44 - 2 * i);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_sat", sat, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    send_and_check("lse_eq", rep(12'd100), rep(12'd100), 2'd0, 4'hF, rep(12'd144), 4'h0);
    send_and_check("lse_d10", rep(12'd200), rep(12'd190), 2'd0, 4'hF, rep(12'd240), 4'h0);
    send_and_check("lse_edge", {12'd100, 12'd100, 12'd4090, 12'd500},
                   {12'd100, 12'd100, 12'd4090, 12'd420}, 2'd0, 4'hF,
                   {12'd144, 12'd144, 12'd4095, 12'd500}, 4'b0010);
    send_and_check("max", rep(12'h800), rep(12'h900), 2'd1, 4'hF, rep(12'h900), 4'h0);
    send_and_check("add", rep(12'h800), rep(12'h900), 2'd2, 4'hF, rep(12'hFFF), 4'hF);
    send_and_check("pass", rep(12'h800), rep(12'h900), 2'd3, 4'hF, rep(12'h800), 4'h0);
    send_and_check("mask", rep(12'd100), rep(12'd100), 2'd0, 4'b0101,
                   {12'd0, 12'd144, 12'd0, 12'd144}, 4'h0);

    // Backpressure: six beats with the sink stalled for five cycles.
    out_ready = 1'b0;
    sent = 0;
    base = n_out;
    for (int c = 0; c < 5; c++) begin
      offer(rep(12'(sent * 37 + 5)), rep(12'(sent * 11 + 3)), 2'(sent), 4'hF, acc);
      if (acc) sent++;
    end
    check("bp_accepted", sent, 3);
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && sent < 6; c++) begin
      offer(rep(12'(sent * 37 + 5)), rep(12'(sent * 11 + 3)), 2'(sent), 4'hF, acc);
      if (acc) sent++;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("bp_out_count", n_out - base, 6);

    // Randomized traffic with a fresh table loaded while the pipeline is empty.
    for (int i = 0; i < 16; i++) lut[i] = 10'($urandom_range(0, 1023));
    base = n_out;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        xv[k*12 +: 12] = 12'($urandom);
        if ($urandom_range(0, 3) != 0)
          yv[k*12 +: 12] = xv[k*12 +: 12] + 12'($urandom_range(0, 80)) - 12'd40;
        else
          yv[k*12 +: 12] = 12'($urandom);
      end
      x_in = xv; y_in = yv;
      pe_mode = 2'($urandom_range(0, 3));
      lane_en = 4'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("rand_drained", exp_q.size(), 0);
    check("rand_traffic", (n_out - base) > 100, 1);

    // Asynchronous reset with beats in flight.
    for (int i = 0; i < 16; i++) lut[i] = 10'(44 - 2 * i);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) offer(rep(12'd100), rep(12'd100), 2'd0, 4'hF, acc);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_result", result, 0);
    check("arst_sat", sat, 0);
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    base = n_out;
    send_and_check("post_rst", rep(12'd300), rep(12'd300), 2'd0, 4'hF, rep(12'd344), 4'h0);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_no_stale", out_valid, 0);
    check("post_rst_count", n_out - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
